// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch squash, data-memory freeze with sticky timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined; otherwise the counter ports read 0.
module hazard_ctrl #(
    parameter int unsigned MAX_MEM_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RnD,
    input  logic [4:0]  RmD,
    input  logic        UseRmD,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        MemToRegE,
    input  logic        BrTakenE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemTimeout,
    output logic [15:0] LoadUseCount,
    output logic [15:0] BranchFlushCount,
    output logic [15:0] FreezeCount
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic freeze;
    logic load_use;

    always_comb begin
        freeze = (((state_q == ST_RUN) || (state_q == ST_MEMWAIT)) && MemReqM && !MemReadyM)
                 || (state_q == ST_TIMEOUT);
        // X31 is the zero register, so a load targeting it never feeds a later reader.
        load_use = RegWriteE && MemToRegE && (RdE != 5'd31)
                   && ((RdE == RnD) || (UseRmD && (RdE == RmD)));
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (BrTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        timeout_d  = timeout_q;
        wait_cnt_d = '0;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
        case (state_q)
            ST_RUN, ST_MEMWAIT: begin
                if (freeze && (wait_cnt_q == WAIT_LAST)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (freeze) begin
                    state_d = ST_MEMWAIT;
                end else if ((state_q == ST_MEMWAIT) && MemReadyM) begin
                    state_d = ST_RUN;
                end
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lu_cnt_q, br_cnt_q, fz_cnt_q;
    logic        lu_act, br_act;

    always_comb begin
        br_act = !freeze && BrTakenE;
        lu_act = !freeze && !BrTakenE && load_use;
    end

    // Counters saturate rather than wrap so a long run never reports a small value.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q <= '0;
            br_cnt_q <= '0;
            fz_cnt_q <= '0;
        end else begin
            if (lu_act && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 16'd1;
            if (br_act && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 16'd1;
            if (freeze && (fz_cnt_q != '1)) fz_cnt_q <= fz_cnt_q + 16'd1;
        end
    end

    assign LoadUseCount     = lu_cnt_q;
    assign BranchFlushCount = br_cnt_q;
    assign FreezeCount      = fz_cnt_q;
`else
    assign LoadUseCount     = '0;
    assign BranchFlushCount = '0;
    assign FreezeCount      = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_MEM_WAIT=4); counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RnD, RmD, RdE;
    logic        UseRmD, RegWriteE, MemToRegE, BrTakenE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [15:0] LoadUseCount, BranchFlushCount, FreezeCount;
    logic [6:0]  outs;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned exp_lu = 0;
    int unsigned exp_br = 0;
    int unsigned exp_fz = 0;

    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_LOADU  = 7'b1100010;
    localparam logic [6:0] O_BRANCH = 7'b0000110;
    localparam logic [6:0] O_FREEZE = 7'b1111001;
    localparam logic [6:0] O_RESET  = 7'b0000111;

    hazard_ctrl #(.MAX_MEM_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .RnD(RnD), .RmD(RmD), .UseRmD(UseRmD), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .BrTakenE(BrTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout),
        .LoadUseCount(LoadUseCount), .BranchFlushCount(BranchFlushCount), .FreezeCount(FreezeCount)
    );

    always #5 clk = ~clk;
    assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    // Inputs change 1 time unit after the rising edge; checks run 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        RnD = 5'd1; RmD = 5'd2; RdE = 5'd9; UseRmD = 1'b0;
        RegWriteE = 1'b0; MemToRegE = 1'b0; BrTakenE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        RdE = 5'd3; RnD = 5'd3; RegWriteE = 1'b1; MemToRegE = 1'b1; MemReqM = 1'b1;
        settle();
        checks++;
        if (outs !== O_RESET) $display("FAIL reset_outs: got %b expected %b", outs, O_RESET);
        else passed++;
        tick(); tick();
        reset = 1'b0;
        idle_inputs();
        exp_lu = 0; exp_br = 0; exp_fz = 0;
        settle();
        checks++;
        if ({outs, MemTimeout} !== 8'b0) $display("FAIL reset_release: got %b expected %b", {outs, MemTimeout}, 8'b0);
        else passed++;
        checks++;
        if ({LoadUseCount, BranchFlushCount, FreezeCount} !== 48'b0)
            $display("FAIL reset_counters: got %h expected %h", {LoadUseCount, BranchFlushCount, FreezeCount}, 48'b0);
        else passed++;
    endtask

    task automatic test_load_use();
        RdE = 5'd3; RegWriteE = 1'b1; MemToRegE = 1'b1; RnD = 5'd3;
        settle();
        checks++;
        if (outs !== O_LOADU) $display("FAIL loaduse_rn: got %b expected %b", outs, O_LOADU);
        else passed++;
        tick(); exp_lu++;
        // load now in Memory; Execute holds the dependent instruction turned bubble
        RegWriteE = 1'b0; MemToRegE = 1'b0;
        settle();
        checks++;
        if (outs !== O_IDLE) $display("FAIL loaduse_one_cycle: got %b expected %b", outs, O_IDLE);
        else passed++;
        checks++;
        if (LoadUseCount !== (PERF ? 16'(exp_lu) : 16'd0))
            $display("FAIL loaduse_count: got %0d expected %0d", LoadUseCount, PERF ? exp_lu : 0);
        else passed++;
        RdE = 5'd31; RnD = 5'd31; RegWriteE = 1'b1; MemToRegE = 1'b1;
        settle();
        checks++;
        if (outs !== O_IDLE) $display("FAIL loaduse_x31: got %b expected %b", outs, O_IDLE);
        else passed++;
        tick();
        RdE = 5'd7; RnD = 5'd1; RmD = 5'd7; UseRmD = 1'b0;
        settle();
        checks++;
        if (outs !== O_IDLE) $display("FAIL loaduse_rm_unused: got %b expected %b", outs, O_IDLE);
        else passed++;
        UseRmD = 1'b1;
        settle();
        checks++;
        if (outs !== O_LOADU) $display("FAIL loaduse_rm: got %b expected %b", outs, O_LOADU);
        else passed++;
        tick(); exp_lu++;
        MemToRegE = 1'b0;
        settle();
        checks++;
        if (outs !== O_IDLE) $display("FAIL loaduse_not_load: got %b expected %b", outs, O_IDLE);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_branch();
        RdE = 5'd5; RmD = 5'd5; UseRmD = 1'b1; RegWriteE = 1'b1; MemToRegE = 1'b1; BrTakenE = 1'b1;
        settle();
        checks++;
        if (outs !== O_BRANCH) $display("FAIL branch_over_loaduse: got %b expected %b", outs, O_BRANCH);
        else passed++;
        tick(); exp_br++;
        idle_inputs();
        settle();
        checks++;
        if (outs !== O_IDLE) $display("FAIL branch_one_cycle: got %b expected %b", outs, O_IDLE);
        else passed++;
        checks++;
        if ({LoadUseCount, BranchFlushCount} !== (PERF ? {16'(exp_lu), 16'(exp_br)} : 32'd0))
            $display("FAIL branch_counts: got lu=%0d br=%0d expected lu=%0d br=%0d",
                     LoadUseCount, BranchFlushCount, PERF ? exp_lu : 0, PERF ? exp_br : 0);
        else passed++;
    endtask

    task automatic test_mem_wait();
        MemReqM = 1'b1; MemReadyM = 1'b0; BrTakenE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (outs !== O_FREEZE) $display("FAIL memwait_freeze%0d: got %b expected %b", i, outs, O_FREEZE);
            else passed++;
            tick(); exp_fz++;
        end
        MemReadyM = 1'b1;
        settle();
        checks++;
        if (outs !== O_BRANCH) $display("FAIL memwait_release_branch: got %b expected %b", outs, O_BRANCH);
        else passed++;
        tick(); exp_br++;
        BrTakenE = 1'b0;
        settle();
        checks++;
        if (outs !== O_IDLE) $display("FAIL memwait_ready_no_freeze: got %b expected %b", outs, O_IDLE);
        else passed++;
        checks++;
        if (FreezeCount !== (PERF ? 16'(exp_fz) : 16'd0))
            $display("FAIL memwait_freezecount: got %0d expected %0d", FreezeCount, PERF ? exp_fz : 0);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if ({outs, MemTimeout} !== {O_FREEZE, 1'b0})
                $display("FAIL timeout_wait%0d: got %b expected %b", i, {outs, MemTimeout}, {O_FREEZE, 1'b0});
            else passed++;
            tick(); exp_fz++;
        end
        MemReqM = 1'b0; MemReadyM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if ({outs, MemTimeout} !== {O_FREEZE, 1'b1})
                $display("FAIL timeout_sticky%0d: got %b expected %b", i, {outs, MemTimeout}, {O_FREEZE, 1'b1});
            else passed++;
            tick(); exp_fz++;
        end
        checks++;
        if (FreezeCount !== (PERF ? 16'(exp_fz) : 16'd0))
            $display("FAIL timeout_freezecount: got %0d expected %0d", FreezeCount, PERF ? exp_fz : 0);
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        exp_lu = 0; exp_br = 0; exp_fz = 0;
        settle();
        checks++;
        if ({outs, MemTimeout} !== 8'b0) $display("FAIL timeout_reset: got %b expected %b", {outs, MemTimeout}, 8'b0);
        else passed++;
        checks++;
        if (FreezeCount !== 16'd0) $display("FAIL timeout_reset_count: got %0d expected 0", FreezeCount);
        else passed++;
    endtask

    task automatic test_reset_midwait();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        checks++;
        if (outs !== O_RESET) $display("FAIL midwait_reset_outs: got %b expected %b", outs, O_RESET);
        else passed++;
        tick();
        reset = 1'b0;
        // a cleared wait counter gives the full 4 frozen cycles before timing out
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if ({outs, MemTimeout} !== {O_FREEZE, 1'b0})
                $display("FAIL midwait_restart%0d: got %b expected %b", i, {outs, MemTimeout}, {O_FREEZE, 1'b0});
            else passed++;
            tick();
        end
        settle();
        checks++;
        if (MemTimeout !== 1'b1) $display("FAIL midwait_timeout: got %b expected 1", MemTimeout);
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        RdE = 5'd4; RnD = 5'd4; RegWriteE = 1'b1; MemToRegE = 1'b1;
        MemReqM = 1'b1; MemReadyM = 1'b0;
        settle();
        checks++;
        if (outs !== O_FREEZE) $display("FAIL b2b_freeze_over_loaduse: got %b expected %b", outs, O_FREEZE);
        else passed++;
        tick();
        MemReadyM = 1'b1;
        settle();
        checks++;
        if (outs !== O_LOADU) $display("FAIL b2b_loaduse_after_freeze: got %b expected %b", outs, O_LOADU);
        else passed++;
        tick();
        checks++;
        if ({LoadUseCount, FreezeCount} !== (PERF ? {16'd1, 16'd1} : 32'd0))
            $display("FAIL b2b_counts: got lu=%0d fz=%0d expected lu=%0d fz=%0d",
                     LoadUseCount, FreezeCount, PERF ? 1 : 0, PERF ? 1 : 0);
        else passed++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_midwait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage LEGv8 CPU. It watches the decode, execute and memory stages and drives the hold/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use interlocks, taken-branch squashes and multi-cycle data-memory waits, with a sticky timeout. It sits beside the datapath in the CPU top level; forwarding muxes are outside its scope.

## Interface
Parameters:
- MAX_MEM_WAIT, default 15: frozen cycles allowed before memory timeout; legal range 1–255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- RnD, RmD  in  5 each  source registers of the instruction in Decode.
- UseRmD  in  1  Decode instruction reads RmD.
- RdE  in  5  destination of the instruction in Execute.
- RegWriteE, MemToRegE  in  1 each  Execute-stage control bits.
- BrTakenE  in  1  branch resolved taken in Execute.
- MemReqM  in  1  Memory stage accesses data memory (load or store).
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1 each  load a bubble (all controls 0) into IF/ID, ID/EX and MEM/WB.
- MemTimeout  out  1  sticky memory-timeout error.
- LoadUseCount, BranchFlushCount, FreezeCount  out  16 each  performance counters (see Configuration).

## Operation
- State register: RUN, MEMWAIT, TIMEOUT. Wait counter waitCnt is 8 bits.
- Stall and flush outputs are combinational from the current state and inputs. State, counters and MemTimeout are registered.
- freeze = (state==MEMWAIT or state==RUN) and MemReqM and !MemReadyM, or state==TIMEOUT.
- loadUse = RegWriteE and MemToRegE and RdE!=31 and (RdE==RnD or (UseRmD and RdE==RmD)). X31 never creates a hazard.
- Priority order: freeze, then branch, then loadUse.
  - freeze: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Else BrTakenE: FlushD=FlushE=1, no stalls. A simultaneous loadUse is ignored because it is on the wrong path.
  - Else loadUse: StallF=StallD=1, FlushE=1.
  - Else all outputs are 0.
- A branch or load-use hazard present during a freeze is held in place. It is acted on in the first unfrozen cycle.
- Transitions:
  - RUN to MEMWAIT when freeze.
  - MEMWAIT to RUN when MemReadyM. The release cycle is unfrozen.
  - RUN or MEMWAIT to TIMEOUT on an edge where freeze and waitCnt==MAX_MEM_WAIT-1.
  - TIMEOUT is left only by reset.
- waitCnt increments on every frozen edge and clears on any unfrozen edge.
- MemTimeout=1 while in TIMEOUT.
- While reset is high: all Stall outputs are 0 and FlushD=FlushE=FlushW=1. On the reset edge, state becomes RUN and waitCnt, MemTimeout and all counters become 0. Reset mid-freeze or in TIMEOUT returns to RUN.

## Timing
- Hazard detection has zero cycles of latency. Outputs respond in the same cycle as the inputs.
- A load-use stall lasts exactly one cycle per hazard. On the next cycle the load is in Memory and loadUse deasserts.
- A branch squash lasts exactly one cycle.
- A memory access with MemReadyM arriving after k not-ready cycles freezes exactly k cycles, for k < MAX_MEM_WAIT.
- With MemReadyM held at 0, the pipeline freezes MAX_MEM_WAIT cycles. TIMEOUT is entered on the following edge.
- MemReqM with MemReadyM=1 in the same cycle causes no freeze.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - LoadUseCount increments on each cycle where the loadUse action is taken.
  - BranchFlushCount increments on each cycle where the branch action is taken.
  - FreezeCount increments on each frozen cycle.
  - All three saturate at 16'hFFFF and clear on reset.
- HAZARD_PERF_CNT_EN undefined: the counter logic is omitted and the three ports are tied to 0. Ports remain present.

## Test plan
- RdE=3, RegWriteE=MemToRegE=1, RnD=3 -> StallF=StallD=FlushE=1 for one cycle. The same test with RdE=31 -> no stall.
- BrTakenE=1 together with a load-use hazard (RmD=RdE=5, UseRmD=1) -> FlushD=FlushE=1, StallF=0, LoadUseCount unchanged, BranchFlushCount +1.
- MemReqM=1 with MemReadyM low for 3 cycles then high -> all stalls and FlushW high exactly 3 cycles, state back to RUN, FreezeCount=3.
- MAX_MEM_WAIT=4, MemReqM=1, MemReadyM=0 forever -> 4 frozen cycles in RUN/MEMWAIT, then MemTimeout=1 and a permanent freeze. Reset -> MemTimeout=0 and state RUN.
- Reset asserted during the 2nd MEMWAIT cycle -> Flush outputs=1, Stall outputs=0, and on the next cycle waitCnt=0 in RUN.
- Build without HAZARD_PERF_CNT_EN and rerun the first test -> all counter ports read 0.
